branch_unit: RTL
================

Name: branch_unit

Overview:
- Branch execution unit: holds dispatched conditional branches until their operands are ready, evaluates them, and broadcasts each outcome on the CDB.
- Broadcast format: cdb_addr = branch PC, cdb_val[0] = taken. This is the format the branch predictor consumes to pop its queue and detect mispredicts.
- Sits between the decoder/dispatch stage and the CDB arbiter, and snoops the CDB for operand values.

Parameters:
- BU_SIZE, 4, number of reservation entries
- BU_SIZE_W, 2, log2(BU_SIZE)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global ready; low = freeze
- flush  in  1  mispredict flush (predictor predict_fail)
- dispatch_valid  in  1  new branch this cycle
- dispatch_pc  in  32  branch instruction address (result tag)
- dispatch_op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- rs1_ready  in  1  rs1_val valid
- rs1_val  in  32  operand 1 value
- rs1_tag  in  32  producer address of operand 1 when not ready
- rs2_ready, rs2_val, rs2_tag  in  1/32/32  same for operand 2
- cdb_active  in  1  snooped broadcast valid
- cdb_addr  in  32  snooped producer address
- cdb_val  in  32  snooped value
- bu_full  out  1  all entries occupied
- cdb_req  out  1  result pending, requesting CDB
- cdb_grant  in  1  arbiter grant for this cycle
- out_active  out  1  broadcast valid
- out_addr  out  32  branch PC
- out_val  out  32  {31'b0, taken}

Behaviour:
- Reset (async, rst_in high): all entries invalid; result register empty; bu_full=0, cdb_req=0, out_active=0, out_addr=0, out_val=0.
- rdy_in low: no state change.
  - Dispatch, snoop and grant are all ignored.
  - out_active is forced 0.
  - cdb_req holds its value.
- Dispatch: when dispatch_valid && !bu_full && !flush, the lowest-index invalid entry captures op, pc and both operands.
  - Same-cycle bypass: if an operand is not ready and cdb_active && cdb_addr==tag && cdb_addr!=0, the entry captures cdb_val as ready.
  - dispatch_valid while bu_full is dropped silently; upstream must stall on bu_full.
- Snoop: every cycle, each valid entry with a non-ready operand whose tag equals cdb_addr (cdb_active, cdb_addr!=0) captures cdb_val and marks that operand ready.
  - A broadcast with cdb_addr==0 never matches.
- Issue:
  - Trigger: at a clock edge where the result register is empty, or is freed by a grant in that same cycle, and some entry has both operands ready.
  - Selection: lowest-index ready entry.
  - Action: the condition is evaluated, the result register is loaded with {pc, taken}, and the entry is invalidated at that edge.
  - Snooped values arriving in the issue cycle are not used for that cycle's selection.
- Comparison rules:
  - BLT/BGE: signed 32-bit.
  - BLTU/BGEU: unsigned.
  - Undefined funct3 (010, 011): taken=0.
- Result register states:
  - EMPTY: cdb_req=0.
  - HELD: cdb_req=1.
  - HELD && cdb_grant && rdy_in: out_active=1 combinationally that cycle, out_addr=pc, out_val={31'b0,taken}. Register returns to EMPTY at the edge, or reloads at that edge if another entry is ready (back-to-back results).
  - HELD without grant: contents stable; out_active=0. out_addr/out_val stay driven from the register.
- Latency: a dispatch with both operands ready at edge N issues at edge N+1; cdb_req is high in cycle N+1; the earliest broadcast is cycle N+1 if granted.
- bu_full: registered view of the occupancy count. An entry freed at the same edge as a dispatch leaves the count unchanged.
- flush: synchronous, with priority over everything else.
  - Clears all entries and the result register; forces cdb_req=0 and out_active=0 that cycle.
  - A dispatch in the flush cycle is dropped.
- Reset mid-operation: asserting rst_in immediately clears all state and outputs, whatever is pending.

Test Plan:
- Reset, dispatch BEQ pc=0x100, rs1=rs2=5 both ready, cdb_grant tied 1 -> cdb_req high one cycle after dispatch edge; same cycle out_active=1, out_addr=0x100, out_val=1.
- Dispatch BLT pc=0x200, rs1_tag=0x80 not ready, rs2=0 ready; later cdb_active with cdb_addr=0x80, cdb_val=0xFFFFFFFF -> entry wakes, broadcasts out_val=1. Repeat as BLTU -> out_val=0.
- Fill 4 entries with unready operands -> bu_full=1; fifth dispatch_valid dropped. Wake entry 2 -> it broadcasts; bu_full drops after issue edge.
- Two ready entries, cdb_grant low 3 cycles -> out_active=0, cdb_req=1, out_addr stable. Grant high 2 cycles -> both results broadcast in consecutive cycles, lowest index first.
- Pending result plus 2 entries held, assert flush -> next cycle cdb_req=0, bu_full=0; a later grant produces no broadcast. A cdb_addr=0 broadcast never wakes an entry with tag 0.
- Hold rdy_in low with a ready entry and grant high -> no issue, out_active=0. Pulse rst_in asynchronously mid-hold -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/branch_unit_if.sv
// Dispatch, CDB-snoop and broadcast signals of the branch execution unit.
// master = dispatch/arbiter side, slave = the branch unit itself.
interface branch_unit_if;
    logic        dispatch_valid;
    logic [31:0] dispatch_pc;
    logic [2:0]  dispatch_op;
    logic        rs1_ready;
    logic [31:0] rs1_val;
    logic [31:0] rs1_tag;
    logic        rs2_ready;
    logic [31:0] rs2_val;
    logic [31:0] rs2_tag;
    logic        cdb_active;
    logic [31:0] cdb_addr;
    logic [31:0] cdb_val;
    logic        bu_full;
    logic        cdb_req;
    logic        cdb_grant;
    logic        out_active;
    logic [31:0] out_addr;
    logic [31:0] out_val;

    modport master (
        output dispatch_valid, dispatch_pc, dispatch_op,
        output rs1_ready, rs1_val, rs1_tag, rs2_ready, rs2_val, rs2_tag,
        output cdb_active, cdb_addr, cdb_val, cdb_grant,
        input  bu_full, cdb_req, out_active, out_addr, out_val
    );

    modport slave (
        input  dispatch_valid, dispatch_pc, dispatch_op,
        input  rs1_ready, rs1_val, rs1_tag, rs2_ready, rs2_val, rs2_tag,
        input  cdb_active, cdb_addr, cdb_val, cdb_grant,
        output bu_full, cdb_req, out_active, out_addr, out_val
    );
endinterface

// File: rtl/branch_unit.sv
// Branch reservation station: waits for operands (dispatch bypass + CDB snoop),
// evaluates the lowest-index ready branch and broadcasts {pc, taken} on the CDB.
module branch_unit #(
    parameter int BU_SIZE   = 4,
    parameter int BU_SIZE_W = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush,
    branch_unit_if.slave bus
);
    localparam int CW = BU_SIZE_W + 1;

    logic [BU_SIZE-1:0] valid_q, valid_d;
    logic [BU_SIZE-1:0] r1_rdy_q, r1_rdy_d, r2_rdy_q, r2_rdy_d;
    logic [2:0]         op_q     [BU_SIZE];
    logic [2:0]         op_d     [BU_SIZE];
    logic [31:0]        pc_q     [BU_SIZE];
    logic [31:0]        pc_d     [BU_SIZE];
    logic [31:0]        r1_val_q [BU_SIZE];
    logic [31:0]        r1_val_d [BU_SIZE];
    logic [31:0]        r1_tag_q [BU_SIZE];
    logic [31:0]        r1_tag_d [BU_SIZE];
    logic [31:0]        r2_val_q [BU_SIZE];
    logic [31:0]        r2_val_d [BU_SIZE];
    logic [31:0]        r2_tag_q [BU_SIZE];
    logic [31:0]        r2_tag_d [BU_SIZE];

    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_pc_q, res_pc_d;
    logic               res_taken_q, res_taken_d;
    logic [CW-1:0]      count_q, count_d;

    logic               snoop_ok;
    logic [BU_SIZE-1:0] r1_hit, r2_hit, ready_vec;
    logic               issue_found, free_found, do_issue, do_disp, grant_free;
    logic [BU_SIZE_W-1:0] issue_idx, free_idx;

    function automatic logic br_taken(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        case (op)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            3'b100:  br_taken = ($signed(a) <  $signed(b));
            3'b101:  br_taken = ($signed(a) >= $signed(b));
            3'b110:  br_taken = (a <  b);
            3'b111:  br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    endfunction

    // A zero producer address means "no producer", so it never wakes anything.
    assign snoop_ok = bus.cdb_active && (bus.cdb_addr != 32'd0);

    for (genvar gi = 0; gi < BU_SIZE; gi++) begin : g_entry
        assign r1_hit[gi]    = valid_q[gi] && !r1_rdy_q[gi] && snoop_ok
                               && (bus.cdb_addr == r1_tag_q[gi]);
        assign r2_hit[gi]    = valid_q[gi] && !r2_rdy_q[gi] && snoop_ok
                               && (bus.cdb_addr == r2_tag_q[gi]);
        assign ready_vec[gi] = valid_q[gi] && r1_rdy_q[gi] && r2_rdy_q[gi];
    end

    assign bus.bu_full    = (count_q == CW'(BU_SIZE));
    assign bus.cdb_req    = res_valid_q && !flush;
    assign bus.out_active = res_valid_q && bus.cdb_grant && rdy_in && !flush;
    assign bus.out_addr   = res_pc_q;
    assign bus.out_val    = {31'd0, res_taken_q};

    always_comb begin
        valid_d     = valid_q;
        r1_rdy_d    = r1_rdy_q;
        r2_rdy_d    = r2_rdy_q;
        op_d        = op_q;
        pc_d        = pc_q;
        r1_val_d    = r1_val_q;
        r1_tag_d    = r1_tag_q;
        r2_val_d    = r2_val_q;
        r2_tag_d    = r2_tag_q;
        res_valid_d = res_valid_q;
        res_pc_d    = res_pc_q;
        res_taken_d = res_taken_q;
        count_d     = count_q;
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        do_issue    = 1'b0;
        do_disp     = 1'b0;
        grant_free  = 1'b0;

        // Descending scan so the lowest index wins.
        for (int i = BU_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                issue_found = 1'b1;
                issue_idx   = BU_SIZE_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = BU_SIZE_W'(i);
            end
        end

        if (flush) begin
            valid_d     = '0;
            res_valid_d = 1'b0;
            res_pc_d    = 32'd0;
            res_taken_d = 1'b0;
            count_d     = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < BU_SIZE; i++) begin
                if (r1_hit[i]) begin
                    r1_rdy_d[i] = 1'b1;
                    r1_val_d[i] = bus.cdb_val;
                end
                if (r2_hit[i]) begin
                    r2_rdy_d[i] = 1'b1;
                    r2_val_d[i] = bus.cdb_val;
                end
            end

            grant_free = res_valid_q && bus.cdb_grant;
            if (grant_free)
                res_valid_d = 1'b0;

            // Selection uses pre-snoop readiness; wakeups count from next cycle.
            do_issue = (!res_valid_q || grant_free) && issue_found;
            if (do_issue) begin
                res_valid_d          = 1'b1;
                res_pc_d             = pc_q[issue_idx];
                res_taken_d          = br_taken(op_q[issue_idx], r1_val_q[issue_idx],
                                                r2_val_q[issue_idx]);
                valid_d[issue_idx]   = 1'b0;
            end

            do_disp = bus.dispatch_valid && !bus.bu_full && free_found;
            if (do_disp) begin
                valid_d[free_idx]  = 1'b1;
                op_d[free_idx]     = bus.dispatch_op;
                pc_d[free_idx]     = bus.dispatch_pc;
                r1_tag_d[free_idx] = bus.rs1_tag;
                r2_tag_d[free_idx] = bus.rs2_tag;
                r1_rdy_d[free_idx] = bus.rs1_ready
                                     || (snoop_ok && bus.cdb_addr == bus.rs1_tag);
                r2_rdy_d[free_idx] = bus.rs2_ready
                                     || (snoop_ok && bus.cdb_addr == bus.rs2_tag);
                r1_val_d[free_idx] = bus.rs1_ready ? bus.rs1_val : bus.cdb_val;
                r2_val_d[free_idx] = bus.rs2_ready ? bus.rs2_val : bus.cdb_val;
            end

            count_d = count_q + CW'(do_disp) - CW'(do_issue);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q     <= '0;
            r1_rdy_q    <= '0;
            r2_rdy_q    <= '0;
            res_valid_q <= 1'b0;
            res_pc_q    <= 32'd0;
            res_taken_q <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < BU_SIZE; i++) begin
                op_q[i]     <= 3'd0;
                pc_q[i]     <= 32'd0;
                r1_val_q[i] <= 32'd0;
                r1_tag_q[i] <= 32'd0;
                r2_val_q[i] <= 32'd0;
                r2_tag_q[i] <= 32'd0;
            end
        end else begin
            valid_q     <= valid_d;
            r1_rdy_q    <= r1_rdy_d;
            r2_rdy_q    <= r2_rdy_d;
            res_valid_q <= res_valid_d;
            res_pc_q    <= res_pc_d;
            res_taken_q <= res_taken_d;
            count_q     <= count_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            r1_val_q    <= r1_val_d;
            r1_tag_q    <= r1_tag_d;
            r2_val_q    <= r2_val_d;
            r2_tag_q    <= r2_tag_d;
        end
    end
endmodule
